// File: rtl/spk_readout_if.sv
// spk_readout_if: core spike-SRAM write snoop plus host start/result handshake
interface spk_readout_if #(
    parameter int CNT_W = 8
);
    logic [15:0]      spk_write_sram;
    logic [8:0]       spk_write_sram_addr;
    logic             spk_write_sram_we;
    logic             start;
    logic             result_ack;
    logic             busy;
    logic [7:0]       ts_count;
    logic             result_valid;
    logic [3:0]       result_class;
    logic [CNT_W-1:0] result_count;
    logic             result_tie;
    modport master (
        output spk_write_sram, spk_write_sram_addr, spk_write_sram_we, start, result_ack,
        input  busy, ts_count, result_valid, result_class, result_count, result_tie
    );
    modport slave (
        input  spk_write_sram, spk_write_sram_addr, spk_write_sram_we, start, result_ack,
        output busy, ts_count, result_valid, result_class, result_count, result_tie
    );
endinterface

// File: rtl/spk_readout.sv
// spk_readout: per-neuron spike counting over a frame, then sequential argmax held for the host
module spk_readout #(
    parameter int         T        = 25,
    parameter int         CNT_W    = 8,
    parameter logic [8:0] OUT_ADDR = 9'h1FF
) (
    input logic          clk,
    input logic          reset,
    spk_readout_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, SCAN, HOLD} state_t;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt [16];
    logic [7:0]       ts;
    logic [4:0]       idx;
    logic [CNT_W-1:0] best;
    logic [3:0]       cls;
    logic             tie;
    logic             qual, clr, last;
    assign qual = bus.spk_write_sram_we && bus.spk_write_sram_addr == OUT_ADDR;
    assign clr  = bus.start && state != SCAN;
    assign last = state == COLLECT && !bus.start && qual && ts == 8'(T - 1);
    always_comb
        state_nx = state == IDLE    ? (bus.start ? COLLECT : IDLE) :
                   state == COLLECT ? (last ? SCAN : COLLECT) :
                   state == SCAN    ? (idx[4] ? HOLD : SCAN) :
                   bus.start        ? COLLECT :
                   bus.result_ack   ? IDLE : HOLD;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    // idx runs 0..16: sixteen compare cycles, then one cycle to hand over to HOLD
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int i = 0; i < 16; i++) cnt[i] <= '0;
            ts   <= '0;
            idx  <= '0;
            best <= '0;
            cls  <= '0;
            tie  <= 1'b0;
        end else begin
            if (clr) begin
                for (int i = 0; i < 16; i++) cnt[i] <= '0;
                ts <= '0;
            end else if (state == COLLECT && qual) begin
                for (int i = 0; i < 16; i++)
                    cnt[i] <= cnt[i] + CNT_W'(bus.spk_write_sram[i] && cnt[i] != '1);
                ts <= ts + 8'd1;
            end
            idx <= (state == SCAN && !idx[4]) ? idx + 5'd1 : '0;
            if (state == SCAN && !idx[4]) begin
                if (idx == '0 || cnt[idx[3:0]] > best) begin
                    best <= cnt[idx[3:0]];
                    cls  <= idx[3:0];
                    tie  <= 1'b0;
                end else if (cnt[idx[3:0]] == best) begin
                    tie <= 1'b1;
                end
            end
        end
    assign bus.busy         = state == COLLECT || state == SCAN;
    assign bus.ts_count     = ts;
    assign bus.result_valid = state == HOLD;
    assign bus.result_class = cls;
    assign bus.result_count = best;
    assign bus.result_tie   = tie;
endmodule

// File: tb/tb_spk_readout.sv
// tb_spk_readout: table-driven frames with a result scoreboard, plus restart/saturation/reset sequences
module tb_spk_readout;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spk_readout_if #(.CNT_W(8)) b4();
    spk_readout_if #(.CNT_W(2)) b6();
    spk_readout #(.T(4), .CNT_W(8), .OUT_ADDR(9'h1FF)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));
    spk_readout #(.T(6), .CNT_W(2), .OUT_ADDR(9'h1FF)) u6 (.clk(clk), .reset(reset), .bus(b6.slave));

    typedef struct packed {
        logic [3:0] cls;
        logic [7:0] cnt;
        logic       tie;
    } res_t;
    typedef struct packed {
        logic [3:0][15:0] w;
        res_t             r;
    } vec_t;

    int   vecs = 0;
    int   errs = 0;
    res_t sb[$];
    vec_t tbl[6];

    function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d,
                                logic [3:0] cl, logic [7:0] cn, logic t);
        vec_t v;
        v.w[0] = a;
        v.w[1] = b;
        v.w[2] = c;
        v.w[3] = d;
        v.r = '{cls: cl, cnt: cn, tie: t};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic wr(bit sel, logic [8:0] a, logic [15:0] d, logic we);
        if (sel) begin
            b6.spk_write_sram_addr = a; b6.spk_write_sram = d; b6.spk_write_sram_we = we;
        end else begin
            b4.spk_write_sram_addr = a; b4.spk_write_sram = d; b4.spk_write_sram_we = we;
        end
        step();
        b4.spk_write_sram_we = 1'b0;
        b6.spk_write_sram_we = 1'b0;
    endtask

    task automatic pulse_start(bit sel);
        if (sel) b6.start = 1'b1; else b4.start = 1'b1;
        step();
        b4.start = 1'b0;
        b6.start = 1'b0;
    endtask

    task automatic wait_res(bit sel, string n, int lat);
        int   k;
        res_t e;
        k = 0;
        while (!(sel ? b6.result_valid : b4.result_valid) && k < 40) begin
            step();
            k++;
        end
        chk({n, " latency"}, k, lat);
        if (sb.size() == 0) begin
            chk({n, " scoreboard"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({n, " class"}, sel ? b6.result_class : b4.result_class, e.cls);
            chk({n, " count"}, sel ? 8'(b6.result_count) : b4.result_count, e.cnt);
            chk({n, " tie"}, sel ? b6.result_tie : b4.result_tie, e.tie);
        end
    endtask

    task automatic ack(bit sel, string n);
        repeat (3) step();
        chk({n, " held"}, sel ? b6.result_valid : b4.result_valid, 1);
        if (sel) b6.result_ack = 1'b1; else b4.result_ack = 1'b1;
        step();
        b4.result_ack = 1'b0;
        b6.result_ack = 1'b0;
        chk({n, " acked valid"}, sel ? b6.result_valid : b4.result_valid, 0);
        chk({n, " acked busy"}, sel ? b6.busy : b4.busy, 0);
    endtask

    task automatic chk_zero(string n);
        chk({n, " busy"}, b4.busy, 0);
        chk({n, " ts"}, b4.ts_count, 0);
        chk({n, " valid"}, b4.result_valid, 0);
        chk({n, " class"}, b4.result_class, 0);
        chk({n, " count"}, b4.result_count, 0);
        chk({n, " tie"}, b4.result_tie, 0);
    endtask

    initial begin
        int seen;
        tbl[0] = mk(16'h0008, 16'h0009, 16'h0008, 16'h0001, 4'd3, 8'd3, 1'b0);
        tbl[1] = mk(16'h8004, 16'h8004, 16'h8004, 16'h8004, 4'd2, 8'd4, 1'b1);
        tbl[2] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'd0, 8'd0, 1'b1);
        tbl[3] = mk(16'h0020, 16'h0020, 16'h0020, 16'h0020, 4'd5, 8'd4, 1'b0);
        tbl[4] = mk(16'h8000, 16'h8000, 16'h8001, 16'h0001, 4'd15, 8'd3, 1'b0);
        tbl[5] = mk(16'hFFFE, 16'h0F0E, 16'hF00E, 16'h4000, 4'd1, 8'd3, 1'b1);
        {b4.spk_write_sram, b4.spk_write_sram_addr, b4.spk_write_sram_we, b4.start, b4.result_ack} = '0;
        {b6.spk_write_sram, b6.spk_write_sram_addr, b6.spk_write_sram_we, b6.start, b6.result_ack} = '0;

        repeat (5) begin
            b4.spk_write_sram = 16'($urandom);
            b4.spk_write_sram_addr = 9'($urandom);
            b4.spk_write_sram_we = 1'($urandom);
            b4.start = 1'($urandom);
            b4.result_ack = 1'($urandom);
            step();
        end
        chk_zero("reset");
        chk("reset u6 valid", b6.result_valid, 0);
        {b4.spk_write_sram, b4.spk_write_sram_addr, b4.spk_write_sram_we, b4.start, b4.result_ack} = '0;
        reset = 1'b1;
        step();
        for (int i = 0; i < 30; i++) wr(0, 9'h1FF, 16'($urandom), 1'b1);
        chk("no start ts", b4.ts_count, 0);
        chk("no start valid", b4.result_valid, 0);
        chk("no start busy", b4.busy, 0);

        foreach (tbl[v]) begin
            pulse_start(0);
            chk($sformatf("vec%0d busy", v), b4.busy, 1);
            chk($sformatf("vec%0d ts0", v), b4.ts_count, 0);
            sb.push_back(tbl[v].r);
            for (int j = 0; j < 4; j++) begin
                wr(0, 9'h1FE, 16'hFFFF, 1'b1);
                wr(0, 9'h1FF, 16'hFFFF, 1'b0);
                wr(0, 9'h1FF, tbl[v].w[j], 1'b1);
                if (j < 3) chk($sformatf("vec%0d ts", v), b4.ts_count, j + 1);
            end
            wait_res(0, $sformatf("vec%0d", v), 17);
            ack(0, $sformatf("vec%0d", v));
        end

        pulse_start(0);
        wr(0, 9'h1FF, 16'h0001, 1'b1);
        wr(0, 9'h1FF, 16'h0001, 1'b1);
        chk("restart ts2", b4.ts_count, 2);
        pulse_start(0);
        chk("restart ts cleared", b4.ts_count, 0);
        b4.start = 1'b1;
        wr(0, 9'h1FF, 16'h0002, 1'b1);
        b4.start = 1'b0;
        chk("start wins over write", b4.ts_count, 0);
        sb.push_back('{cls: 4'd5, cnt: 8'd4, tie: 1'b0});
        repeat (4) wr(0, 9'h1FF, 16'h0020, 1'b1);
        repeat (3) step();
        pulse_start(0);
        chk("scan start ignored busy", b4.busy, 1);
        chk("scan start ignored ts", b4.ts_count, 4);
        wait_res(0, "restart", 13);
        pulse_start(0);
        chk("hold start valid", b4.result_valid, 0);
        chk("hold start busy", b4.busy, 1);
        chk("hold start ts", b4.ts_count, 0);
        sb.push_back('{cls: 4'd6, cnt: 8'd4, tie: 1'b0});
        repeat (4) wr(0, 9'h1FF, 16'h0040, 1'b1);
        wait_res(0, "after hold start", 17);
        ack(0, "after hold start");

        pulse_start(1);
        sb.push_back('{cls: 4'd0, cnt: 8'd3, tie: 1'b1});
        repeat (6) wr(1, 9'h1FF, 16'hFFFF, 1'b1);
        wait_res(1, "saturate", 17);
        ack(1, "saturate");

        pulse_start(0);
        repeat (4) wr(0, 9'h1FF, 16'h0001, 1'b1);
        repeat (5) step();
        chk("mid scan busy", b4.busy, 1);
        chk("mid scan count", b4.result_count, 4);
        #2 reset = 1'b0;
        #1 chk_zero("async reset");
        step();
        reset = 1'b1;
        seen = 0;
        repeat (30) begin
            step();
            if (b4.result_valid) seen = 1;
        end
        chk("no partial result", seen, 0);
        pulse_start(0);
        sb.push_back('{cls: 4'd3, cnt: 8'd4, tie: 1'b0});
        repeat (4) wr(0, 9'h1FF, 16'h0008, 1'b1);
        wait_res(0, "post reset", 17);
        ack(0, "post reset");
        chk("scoreboard drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
